// File: rtl/alu_shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate engine: opcodes, sizes,
// CCR bit positions and the sequencer state type.
package alu_shift_pkg;

  localparam logic [2:0] OP_ASL  = 3'd0;
  localparam logic [2:0] OP_ASR  = 3'd1;
  localparam logic [2:0] OP_LSL  = 3'd2;
  localparam logic [2:0] OP_LSR  = 3'd3;
  localparam logic [2:0] OP_ROXL = 3'd4;
  localparam logic [2:0] OP_ROXR = 3'd5;
  localparam logic [2:0] OP_ROL  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam int CF = 0;
  localparam int VF = 1;
  localparam int ZF = 2;
  localparam int NF = 3;
  localparam int XF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FINISH
  } state_e;

  // Index of the operand MSB for a size code; 2'b11 behaves as long.
  function automatic int activeMsb(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: activeMsb = 7;
      SZ_WORD: activeMsb = 15;
      default: activeMsb = 31;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of the active operand width; bits above the active
// width pass through untouched.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dataIn,
  input  logic [1:0]        size,
  input  logic [2:0]        op,
  input  logic              xIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              outBit,
  output logic              msbChg
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  int                msbInt;
  logic [IW-1:0]     msbIdx;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic              insBit;

  always_comb begin
    msbInt = activeMsb(size);
    if (msbInt > DATA_W - 1) msbInt = DATA_W - 1;
    msbIdx = IW'(msbInt);
    for (int i = 0; i < DATA_W; i++) mask[i] = (i <= msbInt);

    // Even opcodes shift left, odd opcodes shift right.
    outBit = op[0] ? dataIn[0] : dataIn[msbIdx];

    case (op)
      OP_ASR:           insBit = dataIn[msbIdx];
      OP_ROXL, OP_ROXR: insBit = xIn;
      OP_ROL, OP_ROR:   insBit = outBit;
      default:          insBit = 1'b0;
    endcase

    if (!op[0]) begin
      shifted = {dataIn[DATA_W-2:0], insBit};
    end else begin
      shifted         = (dataIn & mask) >> 1;
      shifted[msbIdx] = insBit;
    end

    dataOut = (dataIn & ~mask) | (shifted & mask);
    msbChg  = dataOut[msbIdx] ^ dataIn[msbIdx];
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle 68k shift/rotate engine: STEP_BITS single-bit steps per enabled
// cycle, start/busy/done handshake, 68k-exact result and condition codes.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 6,
  parameter int STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              pwrUp_n,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        op,
  input  logic [1:0]        size,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] operand,
  input  logic              xIn,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        ccrOut,
  output logic [4:0]        ccrMask
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state;
  logic [2:0]        opReg;
  logic [1:0]        sizeReg;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] work;
  logic              xReg;
  logic              cReg;
  logic              vReg;
  logic              zeroCnt;

  logic              isRot;
  logic [CNT_W-1:0]  stepCnt;
  int                msbInt;
  logic [IW-1:0]     msbIdx;
  logic [DATA_W-1:0] activeMask;

  logic [DATA_W-1:0] stepIn   [STEP_BITS];
  logic [DATA_W-1:0] stepOut  [STEP_BITS];
  logic              stepXIn  [STEP_BITS];
  logic              stepXOut [STEP_BITS];
  logic              stepVIn  [STEP_BITS];
  logic              stepVOut [STEP_BITS];
  logic              stepB    [STEP_BITS];
  logic              stepChg  [STEP_BITS];

  logic [DATA_W-1:0] nextData;
  logic              nextX;
  logic              nextC;
  logic              nextV;

  assign isRot = (opReg == OP_ROL) || (opReg == OP_ROR);

  always_comb begin
    msbInt = activeMsb(sizeReg);
    if (msbInt > DATA_W - 1) msbInt = DATA_W - 1;
    msbIdx = IW'(msbInt);
    for (int i = 0; i < DATA_W; i++) activeMask[i] = (i <= msbInt);
  end

  // Chain of single-bit steppers; X threads through so ROXL/ROXR rotate W+1 bits.
  for (genvar g = 0; g < STEP_BITS; g++) begin : gStep
    if (g == 0) begin : gFirst
      assign stepIn[g]  = work;
      assign stepXIn[g] = xReg;
      assign stepVIn[g] = vReg;
    end else begin : gNext
      assign stepIn[g]  = stepOut[g-1];
      assign stepXIn[g] = stepXOut[g-1];
      assign stepVIn[g] = stepVOut[g-1];
    end

    alu_shift_step #(.DATA_W(DATA_W)) uStep (
      .dataIn (stepIn[g]),
      .size   (sizeReg),
      .op     (opReg),
      .xIn    (stepXIn[g]),
      .dataOut(stepOut[g]),
      .outBit (stepB[g]),
      .msbChg (stepChg[g])
    );

    assign stepXOut[g] = isRot ? stepXIn[g] : stepB[g];
    assign stepVOut[g] = stepVIn[g] | stepChg[g];
  end

  // The final step of an operation may shift fewer than STEP_BITS bits.
  always_comb begin
    stepCnt  = (remaining >= CNT_W'(STEP_BITS)) ? CNT_W'(STEP_BITS) : remaining;
    nextData = stepOut[0];
    nextX    = stepXOut[0];
    nextC    = stepB[0];
    nextV    = stepVOut[0];
    for (int i = 0; i < STEP_BITS; i++) begin
      if (CNT_W'(i + 1) == stepCnt) begin
        nextData = stepOut[i];
        nextX    = stepXOut[i];
        nextC    = stepB[i];
        nextV    = stepVOut[i];
      end
    end
  end

  always_ff @(posedge clk or negedge pwrUp_n) begin
    if (!pwrUp_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      ccrOut    <= '0;
      ccrMask   <= '0;
      remaining <= '0;
      opReg     <= '0;
      sizeReg   <= '0;
      work      <= '0;
      xReg      <= 1'b0;
      cReg      <= 1'b0;
      vReg      <= 1'b0;
      zeroCnt   <= 1'b0;
    end else if (en) begin
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            done <= 1'b0;
            if (start) begin
              opReg     <= op;
              sizeReg   <= size;
              remaining <= count;
              work      <= operand;
              xReg      <= xIn;
              cReg      <= (op == OP_ROXL || op == OP_ROXR) ? xIn : 1'b0;
              vReg      <= 1'b0;
              zeroCnt   <= (count == '0);
              busy      <= 1'b1;
              state     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            state <= (remaining != '0) ? ST_SHIFT : ST_FINISH;
          end
          ST_SHIFT: begin
            work      <= nextData;
            xReg      <= nextX;
            cReg      <= nextC;
            vReg      <= nextV;
            remaining <= remaining - stepCnt;
            if (remaining == stepCnt) state <= ST_FINISH;
          end
          ST_FINISH: begin
            result      <= work;
            ccrOut[XF]  <= xReg;
            ccrOut[NF]  <= work[msbIdx];
            ccrOut[ZF]  <= ((work & activeMask) == '0);
            ccrOut[VF]  <= (opReg == OP_ASL) && vReg;
            ccrOut[CF]  <= cReg;
            ccrMask     <= {~(isRot | zeroCnt), 4'b1111};
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: directed vector table, hand-written handshake
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_shift_seq;
  import alu_shift_pkg::*;

  logic        clk = 1'b0;
  logic        pwrUp_n;
  logic        en;
  logic        start;
  logic        abort;
  logic [2:0]  op;
  logic [1:0]  size;
  logic [5:0]  count;
  logic [31:0] operand;
  logic        xIn;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  ccrOut;
  logic [4:0]  ccrMask;

  int total   = 0;
  int passCnt = 0;

  alu_shift_seq #(.DATA_W(32), .CNT_W(6), .STEP_BITS(1)) dut (
    .clk    (clk),
    .pwrUp_n(pwrUp_n),
    .en     (en),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .size   (size),
    .count  (count),
    .operand(operand),
    .xIn    (xIn),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ccrOut (ccrOut),
    .ccrMask(ccrMask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [5:0]  cnt;
    logic [31:0] opnd;
    logic        x;
    logic [31:0] expRes;
    logic [4:0]  expCcr;
    logic [4:0]  expMsk;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: closed-form shift/rotate arithmetic over the active width.
  function automatic void refModel(input logic [2:0] o, input logic [1:0] sz, input int n,
                                   input logic [31:0] opnd, input logic x,
                                   output logic [31:0] res, output logic [4:0] ccr,
                                   output logic [4:0] msk);
    int w, r;
    logic [127:0] m, mm, a, v, t;
    logic c, vf, xo;
    w  = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    m  = (128'd1 << w) - 128'd1;
    mm = (m << 1) | 128'd1;
    a  = {96'd0, opnd} & m;
    c  = 1'b0;
    vf = 1'b0;
    t  = a;
    case (o)
      OP_ASL, OP_LSL: begin
        t = (a << n) & m;
        if (n > 0 && n <= w) c = a[w-n];
        if (o == OP_ASL) begin
          if (n >= w) vf = (a != 0);
          else begin
            v  = a >> (w - 1 - n);
            vf = !(v == 0 || v == ((128'd1 << (n + 1)) - 128'd1));
          end
        end
      end
      OP_ASR: begin
        v = a[w-1] ? (a | ~m) : a;
        t = (n >= w) ? (a[w-1] ? m : 128'd0) : ((v >> n) & m);
        if (n > 0) c = (n <= w) ? a[n-1] : a[w-1];
      end
      OP_LSR: begin
        t = (a >> n) & m;
        if (n > 0 && n <= w) c = a[n-1];
      end
      OP_ROL: begin
        r = n % w;
        t = ((a << r) | (a >> (w - r))) & m;
        c = (n > 0) && t[0];
      end
      OP_ROR: begin
        r = n % w;
        t = ((a >> r) | (a << (w - r))) & m;
        c = (n > 0) && t[w-1];
      end
      OP_ROXL: begin
        r = n % (w + 1);
        v = a | ({127'd0, x} << w);
        v = ((v << r) | (v >> (w + 1 - r))) & mm;
        t = v & m;
        c = v[w];
      end
      default: begin
        r = n % (w + 1);
        v = a | ({127'd0, x} << w);
        v = ((v >> r) | (v << (w + 1 - r))) & mm;
        t = v & m;
        c = v[w];
      end
    endcase
    msk = {!(o == OP_ROL || o == OP_ROR || n == 0), 4'hF};
    xo  = c & msk[4];
    ccr = {xo, t[w-1], (t == 0), vf, c};
    res = (opnd & ~m[31:0]) | t[31:0];
  endfunction

  // Issues one operation with en held high; returns en-cycles from the start
  // edge to the edge after which done is seen (capped at 200).
  task automatic runOp(input logic [2:0] o, input logic [1:0] sz, input logic [5:0] n,
                       input logic [31:0] opnd, input logic x, output int lat);
    op = o; size = sz; count = n; operand = opnd; xIn = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, enCyc, clkCyc;
    logic seenDone, doneOnEn;
    logic [31:0] eRes;
    logic [4:0]  eCcr, eMsk;

    vecs[0] = '{OP_LSL,  2'b01, 6'd1, 32'h0000_8001, 1'b0, 32'h0000_0002, 5'b10001, 5'b11111, 3};
    vecs[1] = '{OP_ASL,  2'b00, 6'd2, 32'hABCD_EF40, 1'b0, 32'hABCD_EF00, 5'b10111, 5'b11111, 4};
    vecs[2] = '{OP_ROXR, 2'b10, 6'd1, 32'h0000_0001, 1'b1, 32'h8000_0000, 5'b11001, 5'b11111, 3};
    vecs[3] = '{OP_ROXR, 2'b10, 6'd0, 32'h0000_0001, 1'b1, 32'h0000_0001, 5'b00001, 5'b01111, 2};
    vecs[4] = '{OP_ROL,  2'b00, 6'd9, 32'h0000_0081, 1'b0, 32'h0000_0003, 5'b00001, 5'b01111, 11};
    vecs[5] = '{OP_LSR,  2'b00, 6'd8, 32'h0000_00A5, 1'b0, 32'h0000_0000, 5'b10101, 5'b11111, 10};
    vecs[6] = '{OP_LSL,  2'b00, 6'd9, 32'h0000_00FF, 1'b1, 32'h0000_0000, 5'b00100, 5'b11111, 11};
    vecs[7] = '{OP_ASR,  2'b01, 6'd4, 32'h0000_8000, 1'b0, 32'h0000_F800, 5'b01000, 5'b11111, 6};
    vecs[8] = '{OP_ROR,  2'b01, 6'd1, 32'h0000_0001, 1'b0, 32'h0000_8000, 5'b01001, 5'b01111, 3};
    vecs[9] = '{OP_ROXL, 2'b00, 6'd1, 32'h0000_0080, 1'b0, 32'h0000_0000, 5'b10101, 5'b11111, 3};

    pwrUp_n = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
    op = '0; size = '0; count = '0; operand = '0; xIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset ccr", {22'd0, ccrOut, ccrMask}, 32'd0);
    pwrUp_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].op, vecs[i].sz, vecs[i].cnt, vecs[i].opnd, vecs[i].x, lat);
      check($sformatf("vec%0d result", i), result, vecs[i].expRes);
      check($sformatf("vec%0d ccr", i), {27'd0, ccrOut & vecs[i].expMsk}, {27'd0, vecs[i].expCcr});
      check($sformatf("vec%0d mask", i), {27'd0, ccrMask}, {27'd0, vecs[i].expMsk});
      check($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
    end

    // en toggling: ASR word 16'h8000 by 4 with en alternating
    en = 1'b1; op = OP_ASR; size = 2'b01; count = 6'd4; operand = 32'h0000_8000; xIn = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; enCyc = 0; clkCyc = 0; doneOnEn = 1'b0;
    while (!done && clkCyc < 100) begin
      en = ~en;
      @(posedge clk); #1;
      clkCyc++;
      if (en) enCyc++;
      if (done) doneOnEn = en;
    end
    check("entog en-cycles", enCyc, 6);
    check("entog done on en", {31'd0, doneOnEn}, 32'd1);
    check("entog stretched", {31'd0, clkCyc > 6}, 32'd1);
    check("entog result", result, 32'h0000_F800);
    check("entog C", {31'd0, ccrOut[CF]}, 32'd0);
    en = 1'b0;
    @(posedge clk); #1;
    check("entog done held", {31'd0, done}, 32'd1);
    en = 1'b1;
    @(posedge clk); #1;
    check("entog done clear", {31'd0, done}, 32'd0);

    // abort mid-SHIFT
    op = OP_LSL; size = 2'b10; count = 6'd20; operand = 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    seenDone = done;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) seenDone = 1'b1;
    end
    check("abort no done", {31'd0, seenDone}, 32'd0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", {31'd0, busy}, 32'd0);
    seenDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || busy) seenDone = 1'b1;
    end
    check("start+abort idle", {31'd0, seenDone}, 32'd0);

    // start while busy is ignored
    op = OP_LSL; size = 2'b10; count = 6'd10; operand = 32'h1; xIn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    operand = 32'h0000_FFFF; count = 6'd1; start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busystart result", result, 32'h0000_0400);
    check("busystart latency", lat, 12);

    // reset mid-SHIFT after a nonzero result
    runOp(OP_LSL, 2'b01, 6'd1, 32'h0000_8001, 1'b0, lat);
    op = OP_LSL; size = 2'b10; count = 6'd20; operand = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    pwrUp_n = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset result", result, 32'd0);
    check("midreset ccr/done", {21'd0, done, ccrOut, ccrMask}, 32'd0);
    @(posedge clk); #1;
    pwrUp_n = 1'b1;
    @(posedge clk); #1;

    // Randomized operations against the model
    for (int i = 0; i < 120; i++) begin
      logic [2:0]  ro;
      logic [1:0]  rs;
      logic [5:0]  rn;
      logic [31:0] rv;
      logic        rx;
      ro = 3'($urandom_range(0, 7));
      rs = 2'($urandom_range(0, 3));
      rn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(41, 63)) : 6'($urandom_range(0, 40));
      rv = $urandom;
      rx = 1'($urandom_range(0, 1));
      refModel(ro, rs, int'(rn), rv, rx, eRes, eCcr, eMsk);
      runOp(ro, rs, rn, rv, rx, lat);
      check($sformatf("rnd%0d result op%0d sz%0d n%0d", i, ro, rs, rn), result, eRes);
      check($sformatf("rnd%0d ccr", i), {27'd0, ccrOut & eMsk}, {27'd0, eCcr});
      check($sformatf("rnd%0d mask", i), {27'd0, ccrMask}, {27'd0, eMsk});
      check($sformatf("rnd%0d latency", i), lat, 2 + int'(rn));
    end

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
